// File: rtl/cpu_pkg.sv
// Constants and types shared by the pipeline stages of the MIPS core.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_fetch_if.sv
// Ready/valid instruction-memory request bus between the fetch stage and imem.
interface if_stage_pc_fetch_if #(
    parameter int unsigned XLEN = cpu_pkg::XLEN
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_pc_fetch_ifid_pipe_reg.sv
// IF/ID pipeline register with flush (highest), load and implicit hold.
module ifid_pipe_reg #(
    parameter int unsigned     XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_plus_4_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_plus_4_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_plus_4_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pc_plus_4_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q     <= 1'b1;
            instr_q     <= instr_i;
            pc_plus_4_q <= pc_plus_4_i;
        end
    end

    assign valid_o     = valid_q;
    assign instr_o     = instr_q;
    assign pc_plus_4_o = pc_plus_4_q;

endmodule

// File: rtl/if_stage_pc_fetch.sv
// Instruction-fetch stage: PC register, imem request FSM and IF/ID load/flush control.
module if_stage_pc_fetch #(
    parameter int unsigned     XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [XLEN-1:0]            next_pc_in,
    input  logic                       redirect,
    input  logic                       stall,
    if_stage_pc_fetch_if.master        imem,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_plus_4_out,
    output logic                       ifid_valid,
    output logic [XLEN-1:0]            ifid_instr,
    output logic [XLEN-1:0]            ifid_pc_plus_4
);

    import cpu_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] target_pc;
    logic            ifid_load, ifid_flush;
    logic [XLEN-1:0] ifid_instr_d;

    assign target_pc     = next_pc_in & ALIGN_MASK;
    assign pc_plus_4_out = pc_q + XLEN'(4);
    assign pc_out        = pc_q;

    // Request is gated by reset so an abandoned fetch never looks outstanding.
    assign imem.imem_req  = rst_n && (state_q != HOLD);
    assign imem.imem_addr = {pc_q[XLEN-1:2], 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        buf_d        = buf_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr_d = buf_q;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem.imem_ready) begin
                        pc_d = target_pc;
                    end else begin
                        pend_pc_d = target_pc;
                        state_d   = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end else begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = imem.imem_rdata;
                        pc_d         = target_pc;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = target_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = target_pc;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                // The stale response is dropped; the newest redirect target always wins.
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem.imem_ready) begin
                        pc_d    = target_pc;
                        state_d = FETCH;
                    end else begin
                        pend_pc_d = target_pc;
                    end
                end else if (imem.imem_ready) begin
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC & ALIGN_MASK;
            pend_pc_q <= '0;
            buf_q     <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            buf_q     <= buf_d;
        end
    end

    ifid_pipe_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ifid_load),
        .flush_i     (ifid_flush),
        .instr_i     (ifid_instr_d),
        .pc_plus_4_i (pc_plus_4_out),
        .valid_o     (ifid_valid),
        .instr_o     (ifid_instr),
        .pc_plus_4_o (ifid_pc_plus_4)
    );

endmodule

// File: tb/tb_if_stage_pc_fetch.sv
// Directed plus randomized bench for the fetch stage against a transaction-level model.
module tb_if_stage_pc_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect;
    logic        stall;
    logic [31:0] next_pc_in;
    logic [31:0] pc_out, pc_plus_4_out, ifid_instr, ifid_pc_plus_4;
    logic        ifid_valid;

    if_stage_pc_fetch_if #(.XLEN(32)) imem_bus ();

    if_stage_pc_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc_in     (next_pc_in),
        .redirect       (redirect),
        .stall          (stall),
        .imem           (imem_bus),
        .pc_out         (pc_out),
        .pc_plus_4_out  (pc_plus_4_out),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus_4 (ifid_pc_plus_4)
    );

    // Second instance reset at the top of the address space.
    logic        w_rst_n;
    logic [31:0] w_next;
    logic [31:0] w_pc, w_pc4, w_instr, w_ifid_pc4;
    logic        w_valid;

    if_stage_pc_fetch_if #(.XLEN(32)) w_bus ();

    if_stage_pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .next_pc_in     (w_next),
        .redirect       (1'b0),
        .stall          (1'b0),
        .imem           (w_bus),
        .pc_out         (w_pc),
        .pc_plus_4_out  (w_pc4),
        .ifid_valid     (w_valid),
        .ifid_instr     (w_instr),
        .ifid_pc_plus_4 (w_ifid_pc4)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: PC, a captured-but-unissued word, and a pending kill of an in-flight fetch.
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_word;
    bit          m_kill;
    logic [31:0] m_tgt;
    bit          m_v;
    logic [31:0] m_i, m_p4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_held = 0; m_word = 32'h0; m_kill = 0; m_tgt = 32'h0;
        m_v = 0; m_i = 32'h0; m_p4 = 32'h0;
    endtask

    task automatic cycle(input bit rst, input bit rd, input bit st, input bit rdy,
                         input logic [31:0] nxt, input logic [31:0] data);
        logic [31:0] tgt;
        rst_n = rst; redirect = rd; stall = st; next_pc_in = nxt;
        imem_bus.imem_ready = rdy; imem_bus.imem_rdata = data;
        #1;
        check("req", {31'b0, imem_bus.imem_req}, {31'b0, rst && !m_held});
        if (rst) check("addr", imem_bus.imem_addr, m_pc);
        check("pc", pc_out, m_pc);
        check("pc_plus_4", pc_plus_4_out, m_pc + 32'd4);
        @(posedge clk);
        tgt = nxt & 32'hFFFF_FFFC;
        if (!rst) begin
            model_reset();
        end else if (rd) begin
            m_v = 0; m_i = 32'h0;
            if (m_held) begin
                m_held = 0; m_pc = tgt;
            end else if (rdy) begin
                m_pc = tgt; m_kill = 0;
            end else begin
                m_kill = 1; m_tgt = tgt;
            end
        end else if (m_held) begin
            if (!st) begin
                m_v = 1; m_i = m_word; m_p4 = m_pc + 32'd4; m_pc = tgt; m_held = 0;
            end
        end else if (rdy) begin
            if (m_kill) begin
                m_pc = m_tgt; m_kill = 0;
            end else if (st) begin
                m_held = 1; m_word = data;
            end else begin
                m_v = 1; m_i = data; m_p4 = m_pc + 32'd4; m_pc = tgt;
            end
        end
        #1;
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
        check("ifid_instr", ifid_instr, m_i);
        check("ifid_pc_plus_4", ifid_pc_plus_4, m_p4);
        check("pc_after", pc_out, m_pc);
    endtask

    initial begin
        rst_n = 0; redirect = 0; stall = 0; next_pc_in = 32'h0;
        imem_bus.imem_ready = 0; imem_bus.imem_rdata = 32'h0;
        w_rst_n = 0; w_next = 32'h0;
        w_bus.imem_ready = 1; w_bus.imem_rdata = 32'h2008_0005;

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_ifid_pc4", ifid_pc_plus_4, 32'h0);
        check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);

        // Zero-wait run.
        cycle(1, 0, 0, 1, 32'h4, 32'h2008_0005);
        check("run_ifid_pc4", ifid_pc_plus_4, 32'h4);
        check("run_valid", {31'b0, ifid_valid}, 32'h1);
        check("run_addr1", imem_bus.imem_addr, 32'h4);
        cycle(1, 0, 0, 1, 32'h8, 32'h2008_0005);
        check("run_addr2", imem_bus.imem_addr, 32'h8);

        // Three stall cycles at PC 0x8.
        cycle(1, 0, 1, 1, 32'hC, 32'h8C01_0008);
        check("stall_pc", pc_out, 32'h8);
        check("stall_req", {31'b0, imem_bus.imem_req}, 32'h0);
        repeat (2) cycle(1, 0, 1, 1, 32'hC, 32'hDEAD_BEEF);
        check("stall_frozen", ifid_instr, 32'h2008_0005);
        check("stall_pc2", pc_out, 32'h8);
        cycle(1, 0, 0, 1, 32'hC, 32'hDEAD_BEEF);
        check("release_instr", ifid_instr, 32'h8C01_0008);
        check("release_pc", pc_out, 32'hC);

        // Redirect with ready.
        cycle(1, 1, 0, 1, 32'h40, 32'h1111_1111);
        check("redir_valid", {31'b0, ifid_valid}, 32'h0);
        check("redir_instr", ifid_instr, 32'h0);
        check("redir_addr", imem_bus.imem_addr, 32'h40);
        cycle(1, 0, 0, 1, 32'h44, 32'h2222_2222);
        cycle(1, 1, 0, 1, 32'h10, 32'h3333_3333);

        // Redirect while the fetch at 0x10 is wait-stated.
        cycle(1, 1, 0, 0, 32'h80, 32'h0);
        check("drain_addr0", imem_bus.imem_addr, 32'h10);
        repeat (2) cycle(1, 0, 0, 0, 32'h14, 32'h0);
        check("drain_addr2", imem_bus.imem_addr, 32'h10);
        check("drain_req", {31'b0, imem_bus.imem_req}, 32'h1);
        cycle(1, 0, 0, 1, 32'h14, 32'hBAD0_0010);
        check("drain_discard", ifid_instr, 32'h0);
        check("drain_next_addr", imem_bus.imem_addr, 32'h80);
        cycle(1, 0, 0, 1, 32'h84, 32'h4444_4444);
        check("post_drain_instr", ifid_instr, 32'h4444_4444);

        // Redirect and stall together: redirect wins.
        cycle(1, 1, 1, 1, 32'h100, 32'h5555_5555);
        check("rs_valid", {31'b0, ifid_valid}, 32'h0);
        check("rs_pc", pc_out, 32'h100);

        // Stall over a bubble keeps it.
        cycle(1, 0, 1, 1, 32'h104, 32'h6666_6666);
        check("bubble_stall", {31'b0, ifid_valid}, 32'h0);
        cycle(1, 0, 0, 1, 32'h104, 32'h7777_7777);
        check("bubble_release", ifid_instr, 32'h6666_6666);

        // Randomized traffic, including occasional mid-run resets.
        for (int k = 0; k < 400; k++) begin
            bit          r_rst, r_rd, r_st, r_rdy;
            logic [31:0] r_nxt;
            r_rst = ($urandom_range(0, 63) != 0);
            r_rd  = ($urandom_range(0, 99) < 15);
            r_st  = ($urandom_range(0, 99) < 25);
            r_rdy = ($urandom_range(0, 99) < 70);
            r_nxt = ($urandom_range(0, 1) == 0) ? (m_pc + 32'd4) : $urandom;
            cycle(r_rst, r_rd, r_st, r_rdy, r_nxt, $urandom);
        end

        // Wrap-around from the top word.
        @(posedge clk);
        #1;
        w_rst_n = 1;
        w_next  = 32'h0;
        #1;
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc4, 32'h0);
        check("wrap_addr0", w_bus.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        check("wrap_addr1", w_bus.imem_addr, 32'h0);
        check("wrap_ifid_pc4", w_ifid_pc4, 32'h0);
        check("wrap_valid", {31'b0, w_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
